// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding imem request,
// one-entry hold buffer for decode stalls, and the decode pipeline register.
module fetch_stage #(
  parameter int PC_W = 16,
  parameter int INSTR_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               FlushD,
  input  logic               BranchTakenE,
  input  logic [PC_W-1:0]    BranchTargetE,
  input  logic               PCSrcW,
  input  logic [PC_W-1:0]    ResultW,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] InstrD,
  output logic [PC_W-1:0]    PCPlus1D,
  output logic               ValidD
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t state_q, state_d;

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic               disc_q, disc_d;
  logic [INSTR_W-1:0] hbuf_q, hbuf_d;
  logic [PC_W-1:0]    hpc_q, hpc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc1_q, pc1_d;
  logic               valid_q, valid_d;

  logic            redirect;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_inc;

  assign redirect = PCSrcW | BranchTakenE;
  assign target   = PCSrcW ? ResultW : BranchTargetE;
  assign pc_inc   = pc_q + 1'b1;

  assign imem_req = reset_n &
                    (((state_q == S_REQ) & ~StallF & ~redirect) |
                     (state_q == S_WAIT));
  // While a request is outstanding the address must not follow a redirect.
  assign imem_addr = (state_q == S_WAIT) ? addr_q : pc_q;

  assign InstrD   = instr_q;
  assign PCPlus1D = pc1_q;
  assign ValidD   = valid_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    disc_d  = disc_q;
    hbuf_d  = hbuf_q;
    hpc_d   = hpc_q;
    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;

    // Decode register becomes a bubble unless it is stalled.
    if (redirect | FlushD | ~StallD) begin
      valid_d = 1'b0;
      instr_d = '0;
    end

    unique case (state_q)
      S_REQ: begin
        if (redirect) begin
          pc_d = target;
        end else if (imem_req) begin
          addr_d = pc_q;
          if (!imem_ack) begin
            state_d = S_WAIT;
          end else if (FlushD) begin
            state_d = S_REQ;
          end else if (StallD) begin
            hbuf_d  = imem_rdata;
            hpc_d   = pc_inc;
            pc_d    = pc_inc;
            state_d = S_HOLD;
          end else begin
            instr_d = imem_rdata;
            pc1_d   = pc_inc;
            valid_d = 1'b1;
            pc_d    = pc_inc;
          end
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          state_d = S_REQ;
          disc_d  = 1'b0;
          if (redirect) begin
            pc_d = target;
          end else if (!disc_q && !FlushD) begin
            pc_d = pc_inc;
            if (StallD) begin
              hbuf_d  = imem_rdata;
              hpc_d   = pc_inc;
              state_d = S_HOLD;
            end else begin
              instr_d = imem_rdata;
              pc1_d   = pc_inc;
              valid_d = 1'b1;
            end
          end
        end else if (redirect) begin
          pc_d   = target;
          disc_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          hbuf_d  = '0;
          hpc_d   = '0;
          state_d = S_REQ;
        end else if (!FlushD && !StallD) begin
          instr_d = hbuf_q;
          pc1_d   = hpc_q;
          valid_d = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      disc_q  <= 1'b0;
      hbuf_q  <= '0;
      hpc_q   <= '0;
      instr_q <= '0;
      pc1_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      disc_q  <= disc_d;
      hbuf_q  <= hbuf_d;
      hpc_q   <= hpc_d;
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run
// checked against an in-order expected-address stream model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        StallF = 1'b0;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;
  logic        BranchTakenE = 1'b0;
  logic [15:0] BranchTargetE = '0;
  logic        PCSrcW = 1'b0;
  logic [15:0] ResultW = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] InstrD;
  logic [15:0] PCPlus1D;
  logic        ValidD;

  fetch_stage #(.PC_W(16), .INSTR_W(32), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
    .PCSrcW(PCSrcW), .ResultW(ResultW),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCPlus1D(PCPlus1D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // stimulus knobs
  logic        stall_f, stall_d, flush_d, br, pcs;
  logic [15:0] br_tgt, res;
  int          lat_cfg;

  // memory responder state
  logic        outst;
  logic [15:0] hold_addr;
  int          cnt, cur_lat;

  // pre-edge snapshot
  logic        pre_req, pre_ack, pre_valid, pre_cont;
  logic [15:0] pre_addr, pre_pc1, pre_hold;
  logic [31:0] pre_instr;

  function automatic logic [31:0] memw(input logic [15:0] a);
    return {a ^ 16'hA5C3, a + 16'h1234};
  endfunction

  task automatic clear_knobs();
    stall_f = 0; stall_d = 0; flush_d = 0;
    br = 0; pcs = 0; br_tgt = '0; res = '0;
  endtask

  task automatic step();
    logic a;
    @(negedge clk);
    StallF = stall_f; StallD = stall_d; FlushD = flush_d;
    BranchTakenE = br; BranchTargetE = br_tgt;
    PCSrcW = pcs; ResultW = res;
    #1;
    pre_req = imem_req; pre_addr = imem_addr;
    pre_valid = ValidD; pre_instr = InstrD; pre_pc1 = PCPlus1D;
    pre_cont = 1'b0; pre_hold = hold_addr;
    a = 1'b0;
    if (imem_req) begin
      if (!outst) begin
        outst = 1'b1; hold_addr = imem_addr; cnt = 0;
        cur_lat = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
      end else begin
        pre_cont = 1'b1; pre_hold = hold_addr;
      end
      a = (cnt == cur_lat);
      cnt++;
    end
    imem_ack = a;
    imem_rdata = a ? memw(imem_addr) : $urandom;
    pre_ack = a;
    @(posedge clk);
    if (a) outst = 1'b0;
    #1;
    imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    clear_knobs(); lat_cfg = 0; outst = 0; hold_addr = '0; cnt = 0; cur_lat = 0;
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({ValidD, InstrD, PCPlus1D, imem_req} !== 50'b0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0",
                      {ValidD, InstrD, PCPlus1D, imem_req});
    end
    reset_n = 1;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin
      bad++; $display("FAIL first_req got=%b/%h exp=1/0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    clear_knobs(); lat_cfg = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (pre_addr !== 16'(i) || ValidD !== 1'b1 || InstrD !== memw(16'(i)) ||
          PCPlus1D !== 16'(i + 1)) begin
        bad++; $display("FAIL zero_wait_%0d got=%h/%b/%h/%h exp=%h/1/%h/%h", i,
                        pre_addr, ValidD, InstrD, PCPlus1D, 16'(i), memw(16'(i)), 16'(i + 1));
      end
    end
    step();
  endtask

  task automatic test_wait_latency();
    clear_knobs(); lat_cfg = 2;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (pre_req !== 1'b1 || pre_addr !== 16'd5 || pre_ack !== (i == 2)) begin
        bad++; $display("FAIL wait_addr_%0d got=%b/%h/%b exp=1/0005/%b", i,
                        pre_req, pre_addr, pre_ack, i == 2);
      end
    end
    total++;
    if (ValidD !== 1'b1 || InstrD !== memw(16'd5) || PCPlus1D !== 16'd6) begin
      bad++; $display("FAIL wait_data got=%b/%h/%h exp=1/%h/0006",
                      ValidD, InstrD, PCPlus1D, memw(16'd5));
    end
  endtask

  task automatic test_hold();
    clear_knobs(); lat_cfg = 0;
    pcs = 1; res = 16'd1; step(); pcs = 0;
    step();
    stall_d = 1; step();
    total++;
    if (ValidD !== 1'b1 || InstrD !== memw(16'd1)) begin
      bad++; $display("FAIL hold_enter got=%b/%h exp=1/%h", ValidD, InstrD, memw(16'd1));
    end
    step();
    total++;
    if (pre_req !== 1'b0 || InstrD !== memw(16'd1)) begin
      bad++; $display("FAIL hold_stay got=%b/%h exp=0/%h", pre_req, InstrD, memw(16'd1));
    end
    stall_d = 0; step();
    total++;
    if (pre_req !== 1'b0 || ValidD !== 1'b1 || InstrD !== memw(16'd2) ||
        PCPlus1D !== 16'd3) begin
      bad++; $display("FAIL hold_release got=%b/%b/%h/%h exp=0/1/%h/0003",
                      pre_req, ValidD, InstrD, PCPlus1D, memw(16'd2));
    end
    step();
    total++;
    if (pre_req !== 1'b1 || pre_addr !== 16'd3) begin
      bad++; $display("FAIL hold_next_req got=%b/%h exp=1/0003", pre_req, pre_addr);
    end
  endtask

  task automatic test_redirect();
    clear_knobs();
    lat_cfg = 0; pcs = 1; res = 16'd7; step(); pcs = 0;
    lat_cfg = 3; step();
    br = 1; br_tgt = 16'h0040; step(); br = 0;
    step();
    total++;
    if (pre_req !== 1'b1 || pre_addr !== 16'd7) begin
      bad++; $display("FAIL redir_old_addr got=%b/%h exp=1/0007", pre_req, pre_addr);
    end
    step();
    total++;
    if (pre_ack !== 1'b1 || ValidD !== 1'b0 || InstrD !== 32'h0) begin
      bad++; $display("FAIL redir_drop got=%b/%b/%h exp=1/0/0", pre_ack, ValidD, InstrD);
    end
    lat_cfg = 0; step();
    total++;
    if (pre_req !== 1'b1 || pre_addr !== 16'h0040 || InstrD !== memw(16'h0040)) begin
      bad++; $display("FAIL redir_target got=%b/%h/%h exp=1/0040/%h",
                      pre_req, pre_addr, InstrD, memw(16'h0040));
    end
    br = 1; br_tgt = 16'h0040; pcs = 1; res = 16'h0080; step();
    clear_knobs(); step();
    total++;
    if (pre_addr !== 16'h0080 || InstrD !== memw(16'h0080)) begin
      bad++; $display("FAIL redir_priority got=%h/%h exp=0080/%h",
                      pre_addr, InstrD, memw(16'h0080));
    end
  endtask

  task automatic test_wrap();
    clear_knobs(); lat_cfg = 0;
    pcs = 1; res = 16'hFFFF; step(); pcs = 0;
    step();
    total++;
    if (pre_addr !== 16'hFFFF || PCPlus1D !== 16'h0 || InstrD !== memw(16'hFFFF)) begin
      bad++; $display("FAIL wrap got=%h/%h/%h exp=ffff/0000/%h",
                      pre_addr, PCPlus1D, InstrD, memw(16'hFFFF));
    end
    step();
    total++;
    if (pre_addr !== 16'h0) begin
      bad++; $display("FAIL wrap_next got=%h exp=0000", pre_addr);
    end
  endtask

  task automatic test_flush();
    clear_knobs(); lat_cfg = 0;
    stall_d = 1; flush_d = 1; step();
    total++;
    if (pre_ack !== 1'b1 || ValidD !== 1'b0 || InstrD !== 32'h0) begin
      bad++; $display("FAIL flush_drop got=%b/%b/%h exp=1/0/0", pre_ack, ValidD, InstrD);
    end
    clear_knobs(); step();
    total++;
    if (pre_addr !== 16'd1 || InstrD !== memw(16'd1)) begin
      bad++; $display("FAIL flush_refetch got=%h/%h exp=0001/%h", pre_addr, InstrD, memw(16'd1));
    end
    stall_d = 1; step();
    flush_d = 1; step();
    total++;
    if (ValidD !== 1'b0 || InstrD !== 32'h0 || pre_req !== 1'b0) begin
      bad++; $display("FAIL flush_hold got=%b/%h/%b exp=0/0/0", ValidD, InstrD, pre_req);
    end
    clear_knobs(); step();
    total++;
    if (ValidD !== 1'b1 || InstrD !== memw(16'd2) || PCPlus1D !== 16'd3) begin
      bad++; $display("FAIL flush_hold_keep got=%b/%h/%h exp=1/%h/0003",
                      ValidD, InstrD, PCPlus1D, memw(16'd2));
    end
  endtask

  task automatic test_reset_mid_wait();
    clear_knobs(); lat_cfg = 0; step();
    stall_d = 1; lat_cfg = 5; step(); step();
    reset_n = 0;
    #1;
    total++;
    if ({ValidD, InstrD, PCPlus1D, imem_req} !== 50'b0) begin
      bad++; $display("FAIL midwait_reset got=%h exp=0", {ValidD, InstrD, PCPlus1D, imem_req});
    end
    imem_ack = 1; imem_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    total++;
    if (ValidD !== 1'b0 || InstrD !== 32'h0 || imem_req !== 1'b0) begin
      bad++; $display("FAIL late_ack got=%b/%h/%b exp=0/0/0", ValidD, InstrD, imem_req);
    end
    imem_ack = 0; outst = 0; clear_knobs();
    StallD = 0;
    reset_n = 1;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin
      bad++; $display("FAIL midwait_restart got=%b/%h exp=1/0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_pc;
    int consumed;
    exp_pc = 16'h0; consumed = 0; lat_cfg = -1;
    for (int n = 0; n < 3000; n++) begin
      stall_f = ($urandom_range(0, 3) == 0);
      stall_d = ($urandom_range(0, 2) == 0);
      flush_d = 0;
      br = ($urandom_range(0, 15) == 0);
      pcs = ($urandom_range(0, 23) == 0);
      br_tgt = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      res = 16'($urandom);
      step();
      if (pre_cont) begin
        total++;
        if (pre_addr !== pre_hold) begin
          bad++; $display("FAIL rand_addr_stable n=%0d got=%h exp=%h", n, pre_addr, pre_hold);
        end
      end
      if (pcs) exp_pc = res;
      else if (br) exp_pc = br_tgt;
      else if (pre_valid && !stall_d) begin
        total++;
        if (pre_instr !== memw(exp_pc) || pre_pc1 !== 16'(exp_pc + 16'd1)) begin
          bad++; $display("FAIL rand_stream n=%0d got=%h/%h exp=%h/%h", n,
                          pre_instr, pre_pc1, memw(exp_pc), 16'(exp_pc + 16'd1));
        end
        exp_pc = exp_pc + 16'd1;
        consumed++;
      end
    end
    total++;
    if (consumed < 300) begin
      bad++; $display("FAIL rand_progress got=%0d exp>=300", consumed);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_latency();
    test_hold();
    test_redirect();
    test_wrap();
    test_flush();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
